// File: rtl/sort_pkg.sv
// Shared constants and types for the bubble-sorter frame feeder.
package sort_pkg;

  localparam logic [31:0] SORT_SENTINEL  = 32'h7FFF_FFFF;
  localparam logic [31:0] SORT_CLAMP     = 32'h7FFF_FFFE;
  localparam int          SORT_FRAME_LEN = 5;

  typedef enum logic {
    FILL = 1'b0,
    PAD  = 1'b1
  } feed_state_e;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } feed_entry_t;

  // The sentinel marks an empty sorter slot, so real data must never carry it.
  function automatic logic [31:0] sort_clamp(input logic [31:0] d);
    return (d == SORT_SENTINEL) ? SORT_CLAMP : d;
  endfunction

endpackage

// File: rtl/sort_feed_fifo.sv
// Small synchronous FIFO; full/empty from read/write pointers with one extra wrap bit.
module sort_feed_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/sort_frame_feeder.sv
// Buffers a valid/ready sample stream and feeds the sorter's put method in
// fixed-length frames, padding short frames with the empty sentinel.
module sort_frame_feeder
  import sort_pkg::*;
#(
  parameter int FRAME_LEN  = SORT_FRAME_LEN,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      put_x,
  output logic             EN_put,
  input  logic             RDY_put,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] clamp_count,
  output logic             busy
);

  localparam int SLOT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  feed_state_e       r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic              w_full, w_empty, w_push, w_pop, w_frame_done, w_clamp_hit;
  feed_entry_t       w_wentry, w_head;

  assign in_ready    = !w_full;
  assign w_push      = in_valid && !w_full;
  assign w_wentry    = '{last: in_last, data: sort_clamp(in_data)};
  assign w_clamp_hit = w_push && (in_data == SORT_SENTINEL);
  assign busy        = !w_empty || (r_state == PAD);

  sort_feed_fifo #(
    .WIDTH ($bits(feed_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      r_state     <= FILL;
      r_slot      <= '0;
      frame_count <= '0;
      clamp_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      if (w_frame_done) frame_count <= frame_count + CNT_ONE;
      if (w_clamp_hit)  clamp_count <= clamp_count + CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_frame_done = 1'b0;
    w_pop        = 1'b0;
    EN_put       = 1'b0;
    put_x        = SORT_SENTINEL;
    unique case (r_state)
      FILL: begin
        if (!w_empty && RDY_put) begin
          EN_put = 1'b1;
          put_x  = w_head.data;
          w_pop  = 1'b1;
          // A full frame closes itself regardless of the last flag.
          if (r_slot == SLOT_LAST) begin
            w_slot_nxt   = '0;
            w_frame_done = 1'b1;
          end else begin
            w_slot_nxt = r_slot + SLOT_ONE;
            if (w_head.last) w_state_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (RDY_put) begin
          EN_put = 1'b1;
          if (r_slot == SLOT_LAST) begin
            w_slot_nxt   = '0;
            w_frame_done = 1'b1;
            w_state_nxt  = FILL;
          end else begin
            w_slot_nxt = r_slot + SLOT_ONE;
          end
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

endmodule

// File: tb/tb_sort_frame_feeder.sv
// Directed and randomized checks of sort_frame_feeder against a frame-level model.
module tb_sort_frame_feeder;

  localparam int          FL   = 5;
  localparam logic [31:0] SENT = 32'h7FFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [31:0] put_x;
  logic        EN_put;
  logic        RDY_put = 1'b1;
  logic [15:0] frame_count, clamp_count;
  logic        busy;

  sort_frame_feeder #(.FRAME_LEN(FL), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .put_x(put_x), .EN_put(EN_put),
    .RDY_put(RDY_put), .frame_count(frame_count), .clamp_count(clamp_count),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int          tests = 0, fails = 0, cyc = 0, viol = 0;
  bit          rnd_rdy = 0;
  logic [31:0] obs_q[$], exp_q[$], in_d[$];
  int          obs_cyc[$], acc_cyc[$];
  bit          in_l[$];
  int          exp_frames, exp_clamps;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (EN_put) begin
      obs_q.push_back(put_x);
      obs_cyc.push_back(cyc);
      if (!RDY_put) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame-level view: every sample is one put, a frame closes at FL slots,
  // and a last flag before that is followed by sentinels up to FL slots.
  task automatic build_exp();
    int slot = 0;
    exp_q.delete(); exp_frames = 0; exp_clamps = 0;
    foreach (in_d[i]) begin
      if (in_d[i] == SENT) begin exp_q.push_back(32'h7FFF_FFFE); exp_clamps++; end
      else exp_q.push_back(in_d[i]);
      slot++;
      if (slot == FL || in_l[i]) begin
        while (slot < FL) begin exp_q.push_back(SENT); slot++; end
        slot = 0; exp_frames++;
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 0;
    RST_N = 1;
    @(posedge CLK); #1;
    @(negedge CLK); RST_N = 0;
    @(posedge CLK); #1;
    obs_q.delete(); obs_cyc.delete(); acc_cyc.delete();
    in_d.delete(); in_l.delete(); viol = 0;
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    bit acc = 0;
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!acc && n < 100) begin
      @(negedge CLK);
      acc = in_ready;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge CLK); #1;
      n++;
      if (rnd_rdy) RDY_put = ($urandom_range(0, 3) != 0);
    end
    in_valid = 0;
    check("accept", 32'(acc), 32'd1);
    if (acc) begin in_d.push_back(d); in_l.push_back(l); end
  endtask

  task automatic drain_and_check(input string tag);
    int n = 0;
    int sz;
    build_exp();
    while (obs_q.size() < exp_q.size() && n < 400) begin
      @(posedge CLK); #1; n++;
      if (rnd_rdy) RDY_put = ($urandom_range(0, 3) != 0);
    end
    RDY_put = 1;
    sz = obs_q.size();
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    repeat (8) @(posedge CLK);
    #1;
    check({tag, " put_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    check({tag, " no_late_puts"}, 32'(obs_q.size()), 32'(sz));
    foreach (exp_q[i])
      check($sformatf("%s put%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    check({tag, " frame_count"}, 32'(frame_count), 32'(exp_frames));
    check({tag, " clamp_count"}, 32'(clamp_count), 32'(exp_clamps));
    check({tag, " rdy_violations"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] d;
    do_reset();
    check("rst EN_put", 32'(EN_put), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst put_x", put_x, SENT);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_count", 32'(frame_count), 32'd0);
    check("rst clamp_count", 32'(clamp_count), 32'd0);

    // Full frame on consecutive cycles, one cycle after the first accept.
    send(32'd3, 0); send(-32'sd1, 0); send(32'd7, 0); send(32'd0, 0); send(32'd2, 1);
    drain_and_check("full");
    check("full latency", 32'(obs_cyc[0]), 32'(acc_cyc[0] + 1));
    check("full back2back", 32'(obs_cyc[4]), 32'(obs_cyc[0] + 4));

    do_reset();
    send(32'd10, 0); send(32'd20, 1);
    drain_and_check("short");

    do_reset();
    send(SENT, 0); send(32'h8000_0000, 0); send(32'd1, 0); send(32'd2, 0); send(32'd3, 0);
    drain_and_check("clamp");

    // Stalled sorter: the FIFO fills at 4 and the 5th sample is refused.
    do_reset();
    RDY_put = 0;
    for (int i = 0; i < 4; i++) send(32'd100 + 32'(i), 0);
    in_valid = 1; in_data = 32'd104; in_last = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("bp in_ready%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp EN_put%0d", i), 32'(EN_put), 32'd0);
      @(posedge CLK); #1;
    end
    check("bp no_puts", 32'(obs_q.size()), 32'd0);
    RDY_put = 1;
    send(32'd104, 0); send(32'd105, 0);
    drain_and_check("backpressure");

    // Seven samples without last roll into a second frame, then close it.
    do_reset();
    for (int i = 0; i < 7; i++) send(32'd200 + 32'(i), 0);
    drain_and_check("auto");
    send(32'd207, 1);
    drain_and_check("auto_close");

    // Reset while padding.
    do_reset();
    send(32'd55, 1);
    n = 0;
    while (obs_q.size() < 2 && n < 50) begin @(posedge CLK); #1; n++; end
    check("midpad reached", 32'(obs_q.size()), 32'd2);
    check("midpad busy", 32'(busy), 32'd1);
    RST_N = 1;
    #1;
    check("midpad EN_put", 32'(EN_put), 32'd0);
    check("midpad in_ready", 32'(in_ready), 32'd1);
    check("midpad put_x", put_x, SENT);
    check("midpad frame_count", 32'(frame_count), 32'd0);
    check("midpad busy_rst", 32'(busy), 32'd0);
    do_reset();
    send(32'd1, 0); send(32'd2, 1);
    drain_and_check("post_reset");

    // Random samples, last flags and sorter readiness.
    do_reset();
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: d = SENT;
        1: d = 32'h8000_0000;
        default: d = $urandom;
      endcase
      send(d, (i == 39) || ($urandom_range(0, 4) == 0));
    end
    drain_and_check("random");
    rnd_rdy = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sort_frame_feeder.md
Name: sort_frame_feeder

Overview:
Upstream feeder for the 5-entry bubble sorter. It accepts a valid/ready stream of signed 32-bit samples with an end-of-frame marker and buffers them in a small FIFO. It drives the sorter's put method (put_x/EN_put/RDY_put), grouping samples into frames of FRAME_LEN. Short frames are padded with the sorter's empty sentinel, and any input equal to the sentinel is clamped so it cannot be mistaken for an empty slot.

Parameters:
FRAME_LEN, 5, slots per sorter frame; must equal the sorter depth.
FIFO_DEPTH, 4, input buffer entries; power of two, >= 2.
CNT_W, 16, width of the statistics counters.

Ports:
CLK  input  1  clock; all state on posedge.
RST_N  input  1  asynchronous, active-high reset (asserted = 1).
in_valid  input  1  upstream sample valid.
in_ready  output  1  feeder can accept a sample.
in_data  input  32  signed sample.
in_last  input  1  sample closes the current frame.
put_x  output  32  value to the sorter's put.
EN_put  output  1  put enable; asserted only when RDY_put = 1.
RDY_put  input  1  sorter ready to accept put.
frame_count  output  CNT_W  frames fully delivered; wraps.
clamp_count  output  CNT_W  samples clamped; wraps.
busy  output  1  FIFO non-empty or state != FILL.

Behaviour:
- Interface: one clock, CLK; reset RST_N is asynchronous and active-high.
- Reset values:
  - FIFO empty; state FILL; slot = 0; counters 0.
  - in_ready = 1, EN_put = 0, put_x = 32'h7FFFFFFF, busy = 0.
- Input side:
  - Handshake fires when in_valid && in_ready.
  - in_ready = !fifo_full. There is no bypass, so a full FIFO does not accept even when it pops in the same cycle.
  - Each entry holds {last, data}. Clamping is applied at the write: in_data == 32'h7FFFFFFF is stored as 32'h7FFFFFFE and clamp_count increments.
  - All other values, including 32'h80000000, pass unchanged.
- Latency: a sample accepted in cycle t can drive EN_put no earlier than cycle t+1.
- State machine, states FILL and PAD; slot is a counter over 0..FRAME_LEN-1.
- FILL:
  - EN_put = fifo_nonempty && RDY_put, with put_x = head.data.
  - On each put, the head is popped.
  - If slot == FRAME_LEN-1, then slot becomes 0 and frame_count increments, whatever head.last is.
  - Otherwise, if head.last = 1, the block enters PAD and slot increments.
  - Otherwise, slot increments.
  - When EN_put = 0, put_x = 32'h7FFFFFFF.
- PAD:
  - EN_put = RDY_put, with put_x = 32'h7FFFFFFF. The FIFO is not popped, and input acceptance continues.
  - On each put, slot increments. When the put fills slot FRAME_LEN-1, slot becomes 0, frame_count increments and the block returns to FILL.
- Frame boundaries:
  - in_last on slot FRAME_LEN-1 produces no padding.
  - Samples beyond FRAME_LEN without in_last start a new frame automatically.
  - in_last on slot 0 of an otherwise empty frame produces 1 data put and FRAME_LEN-1 pads.
- Flow control:
  - The feeder never asserts EN_put with RDY_put low.
  - When the sorter holds a full frame, RDY_put is low and the feeder stalls. The FIFO then fills and in_ready drops.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged.
- Reset mid-operation (including mid-PAD) returns the block to the reset values immediately. Any partial frame is discarded; the sorter is reset by the same RST_N.
- busy = fifo_nonempty || state == PAD.

Decomposition:
- Package sort_pkg holds:
  - SORT_SENTINEL = 32'h7FFFFFFF;
  - SORT_CLAMP = 32'h7FFFFFFE;
  - SORT_FRAME_LEN = 5;
  - the feeder state enum {FILL, PAD};
  - the FIFO entry typedef {last, data[31:0]}.
- One sub-module: sort_feed_fifo, a synchronous FIFO with parameters width and depth. It has push, pop, full, empty and head outputs, and pointer-plus-one-bit full/empty detection.
- Clamping and the FSM stay in the top level.

Test Plan:
- Full frame: send 3, -1, 7, 0, 2 with last on the 5th, RDY_put = 1 → 5 puts in order 3, -1, 7, 0, 2 on consecutive cycles starting 1 cycle after the first accept; frame_count = 1.
- Short frame: send 10, 20 with last on 20 → puts 10, 20, then three 7FFFFFFF; frame_count = 1; busy = 0 after the 5th put.
- Clamp: send 7FFFFFFF, 80000000, 1, 2, 3 → put_x = 7FFFFFFE, 80000000, 1, 2, 3; clamp_count = 1.
- Backpressure: hold RDY_put = 0 and offer 6 samples → exactly 4 accepted; in_ready = 0 and EN_put = 0 while stalled; raise RDY_put → 4 puts in order, then the 5th and 6th.
- Auto-boundary: 7 samples with no last → frame_count = 1 after the 5th put; samples 6 and 7 go into slots 0 and 1 of the next frame.
- Reset mid-PAD: assert RST_N after the 1st pad put → next cycle EN_put = 0, in_ready = 1, slot = 0, frame_count = 0, put_x = 7FFFFFFF.
